bcd_digit_scanner: RTL and testbench

- Time-multiplexed scan driver for a multi-digit common-anode seven-segment display.
- Holds a packed BCD word and steps through the digits one at a time. Each step presents one 4-bit code on nibble[3:0] (w=nibble[3] … z=nibble[0]) to the downstream BCD-to-seven-segment decoder and drives the matching active-low anode.
- Sits directly upstream of that decoder. Blanked digits are sent as code 4'hF, which the decoder renders as all segments off.

---
 rtl/bcd_digit_scanner.sv | 106 ++++++++++
 tb/tb_bcd_digit_scanner.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/bcd_digit_scanner.sv
// Time-multiplexed digit scanner feeding a BCD-to-seven-segment decoder (active-low anodes).
// Optional leading-zero blanking is enabled with the macro LEADING_ZERO_BLANK_EN.
module bcd_digit_scanner #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 50000,
    parameter int IDX_W    = $clog2(DIGITS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic [3:0]            nibble,
    output logic [DIGITS-1:0]     an_n,
    output logic [IDX_W-1:0]      digit_idx,
    output logic                  frame_done
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  active_q, active_d;
    logic                  frame_done_q, frame_done_d;
    logic [4*DIGITS-1:0]   disp_q, disp_d;
    logic [4*DIGITS-1:0]   pend_q, pend_d;
    logic                  pend_valid_q, pend_valid_d;
    logic                  tick, wrap;

    // The counter holds on the release edge so digit 0 gets its full PRESCALE cycles.
    always_comb begin
        tick         = active_q && (cnt_q == CNT_W'(PRESCALE - 1));
        wrap         = tick && (idx_q == IDX_W'(DIGITS - 1));
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        active_d     = 1'b1;
        frame_done_d = wrap;
        disp_d       = disp_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;

        if (active_q)
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        if (tick)
            idx_d = wrap ? '0 : idx_q + IDX_W'(1);

        if (load) begin
            pend_d       = bcd_in;
            pend_valid_d = 1'b1;
        end
        if (wrap) begin
            if (load) begin
                disp_d       = bcd_in;
                pend_valid_d = 1'b0;
            end else if (pend_valid_q) begin
                disp_d       = pend_q;
                pend_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            active_q     <= 1'b0;
            frame_done_q <= 1'b0;
            disp_q       <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            active_q     <= active_d;
            frame_done_q <= frame_done_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
        end
    end

    // Walk from the top digit down so "all higher digits are zero" accumulates as we go.
    always_comb begin
        logic [3:0] digit_v;
        logic       higher_zero_v;
        an_n          = '1;
        nibble        = 4'hF;
        higher_zero_v = 1'b1;
        digit_v       = 4'h0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            digit_v = disp_q[4*k +: 4];
            if (active_q && (idx_q == IDX_W'(k))) begin
                an_n[k] = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
                nibble  = ((k > 0) && higher_zero_v && (digit_v == 4'h0)) ? 4'hF : digit_v;
`else
                nibble  = digit_v;
`endif
            end
            higher_zero_v = higher_zero_v && (digit_v == 4'h0);
        end
    end

    assign digit_idx  = idx_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_digit_scanner.sv
// Self-checking bench for bcd_digit_scanner (DIGITS=4, PRESCALE=4): a frame table feeds a
// per-cycle scoreboard of {inputs, expected outputs}, popped and compared one edge at a time.
module tb_bcd_digit_scanner;

    localparam int DIGITS   = 4;
    localparam int PRESCALE = 4;
    localparam int IDX_W    = 2;
    localparam int FRAME    = DIGITS * PRESCALE;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                load = 1'b0;
    logic [15:0]         bcd_in = 16'h0;
    logic [3:0]          nibble;
    logic [3:0]          an_n;
    logic [IDX_W-1:0]    digit_idx;
    logic                frame_done;

    int n_tests = 0;
    int n_fail  = 0;

    bcd_digit_scanner #(.DIGITS(DIGITS), .PRESCALE(PRESCALE)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .bcd_in     (bcd_in),
        .nibble     (nibble),
        .an_n       (an_n),
        .digit_idx  (digit_idx),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // One scoreboard entry: inputs held across one rising edge, outputs expected after it.
    typedef struct {
        logic        rst;
        logic        load;
        logic [15:0] bcd;
        logic [3:0]  an;
        logic [3:0]  nib;
        logic        fd;
        logic [1:0]  idx;
        string       name;
    } vec_t;

    // One frame of stimulus: n cycles showing 'shown', optional load at cycle load_j.
    typedef struct {
        logic [15:0] shown;
        bit          fd_first;
        int          load_j;
        logic [15:0] load_val;
        int          n;
        bit          rst_after;
        string       name;
    } frame_t;

    vec_t sb[$];

    function automatic logic [3:0] exp_nib(logic [15:0] v, int k);
        logic [3:0] d;
        bit         allz;
        d = v[4*k +: 4];
        allz = 1'b1;
        for (int m = k; m < DIGITS; m++)
            if (v[4*m +: 4] != 4'h0) allz = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        if (k > 0 && allz) return 4'hF;
`endif
        return d;
    endfunction

    task automatic push_reset(input int n, input string name);
        vec_t e;
        for (int i = 0; i < n; i++) begin
            e.rst = 1'b1; e.load = 1'b0; e.bcd = 16'h0;
            e.an = 4'b1111; e.nib = 4'hF; e.fd = 1'b0; e.idx = 2'd0;
            e.name = name;
            sb.push_back(e);
        end
    endtask

    task automatic push_frame(input frame_t f);
        vec_t e;
        int   d;
        logic [3:0] one_hot;
        for (int j = 0; j < f.n; j++) begin
            d = j / PRESCALE;
            one_hot = 4'b0001 << d;
            e.rst  = 1'b0;
            e.load = (j == f.load_j);
            e.bcd  = (j == f.load_j) ? f.load_val : 16'hDEAD;
            e.an   = ~one_hot;
            e.nib  = exp_nib(f.shown, d);
            e.fd   = (j == 0) && f.fd_first;
            e.idx  = 2'(d);
            e.name = f.name;
            sb.push_back(e);
        end
        if (f.rst_after) push_reset(1, {f.name, "_rst"});
    endtask

    task automatic run_scoreboard();
        vec_t e;
        int   cyc;
        cyc = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rst    = e.rst;
            load   = e.load;
            bcd_in = e.bcd;
            @(posedge clk);
            #1;
            n_tests++;
            if (an_n !== e.an || nibble !== e.nib || frame_done !== e.fd || digit_idx !== e.idx) begin
                n_fail++;
                $display("FAIL %s cyc %0d: got an_n=%b nibble=%h frame_done=%b idx=%0d, want an_n=%b nibble=%h frame_done=%b idx=%0d",
                         e.name, cyc, an_n, nibble, frame_done, digit_idx, e.an, e.nib, e.fd, e.idx);
            end
            cyc++;
        end
        load = 1'b0;
    endtask

    frame_t frames[16];

    initial begin
        frames[0]  = '{16'h0000, 1'b0, -1, 16'h0000, FRAME, 1'b0, "post_reset"};
        frames[1]  = '{16'h0000, 1'b1,  5, 16'h1234, FRAME, 1'b0, "load_mid"};
        frames[2]  = '{16'h1234, 1'b1, -1, 16'h0000, FRAME, 1'b0, "show_1234"};
        frames[3]  = '{16'h1234, 1'b1, -1, 16'h0000, FRAME, 1'b0, "free_run"};
        frames[4]  = '{16'h1234, 1'b1, -1, 16'h0000, FRAME, 1'b0, "free_run"};
        frames[5]  = '{16'h1234, 1'b1, -1, 16'h0000, FRAME, 1'b0, "free_run"};
        frames[6]  = '{16'h1234, 1'b1, -1, 16'h0000, FRAME, 1'b0, "free_run"};
        frames[7]  = '{16'h5678, 1'b1,  0, 16'h5678, FRAME, 1'b0, "load_at_wrap"};
        frames[8]  = '{16'h5678, 1'b1, -1, 16'h0000, FRAME, 1'b0, "after_wrap_load"};
        frames[9]  = '{16'h5678, 1'b1,  2, 16'h9999, 10,    1'b1, "reset_mid"};
        frames[10] = '{16'h0000, 1'b0, -1, 16'h0000, FRAME, 1'b0, "restart"};
        frames[11] = '{16'h0000, 1'b1,  5, 16'h0070, FRAME, 1'b0, "no_9999"};
        frames[12] = '{16'h0070, 1'b1,  5, 16'h0000, FRAME, 1'b0, "show_0070"};
        frames[13] = '{16'h0000, 1'b1,  5, 16'h1000, FRAME, 1'b0, "show_0000"};
        frames[14] = '{16'h1000, 1'b1,  5, 16'h0A0B, FRAME, 1'b0, "show_1000"};
        frames[15] = '{16'h0A0B, 1'b1, -1, 16'h0000, FRAME, 1'b0, "invalid_bcd"};

        push_reset(3, "reset_hold");
        for (int i = 0; i < 16; i++) push_frame(frames[i]);
        run_scoreboard();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
